// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute-stage sequencer.
package alu_pkg;

  localparam int DW = 16;

  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_CMP  = 3'b010,
    OP_INC  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_NOTA = 3'b110,
    OP_NOTB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction-in and result-out handshakes of the execute stage.
interface alu_exec_ctrl_if
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = alu_pkg::DW
);
  localparam int AW = $clog2(NREGS);

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;

  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_rd;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, res_ready,
    input  in_ready, res_valid, res_data, res_rd
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, res_ready,
    output in_ready, res_valid, res_data, res_rd
  );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x DW register file: two async read ports, host and writeback write
// ports; the writeback port wins when both hit the same address.
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DW-1:0]            rdata_a,
  output logic [DW-1:0]            rdata_b,
  input  logic                     host_we,
  input  logic [$clog2(NREGS)-1:0] host_waddr,
  input  logic [DW-1:0]            host_wdata,
  input  logic                     wb_we,
  input  logic [$clog2(NREGS)-1:0] wb_waddr,
  input  logic [DW-1:0]            wb_wdata
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

  // Writeback is applied last so it overrides a same-address host write.
  always_comb begin
    regs_d = regs_q;
    if (host_we) regs_d[host_waddr] = host_wdata;
    if (wb_we)   regs_d[wb_waddr]   = wb_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer (IDLE -> EXEC -> WB) around an external combinational ALU.
// Define ALU_EXEC_PERF_EN to add the retired_cnt instruction counter port.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = alu_pkg::DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_exec_ctrl_if.slave           bus,
  input  logic                     host_we,
  input  logic [$clog2(NREGS)-1:0] host_waddr,
  input  logic [DW-1:0]            host_wdata,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [2:0]               alu_op,
  input  logic [DW-1:0]            alu_out,
  input  logic [2:0]               alu_flags,
  output logic [2:0]               flags_q
`ifdef ALU_EXEC_PERF_EN
  ,
  output logic [31:0]              retired_cnt
`endif
);

  localparam int AW = $clog2(NREGS);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_WB   = WB;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [2:0]    res_flags_q, res_flags_d;
  logic          wb_first_q, wb_first_d;
  logic [2:0]    flags_d;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          accept, res_fire, wb_we;

  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_WB);
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = rd_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign res_fire = bus.res_valid && bus.res_ready;
  assign wb_we    = wb_first_q && (alu_op_q != OP_CMP);

  alu_regfile #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr_a    (bus.in_rs1),
    .raddr_b    (bus.in_rs2),
    .rdata_a    (rdata_a),
    .rdata_b    (rdata_b),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .wb_we      (wb_we),
    .wb_waddr   (rd_q),
    .wb_wdata   (res_data_q)
  );

  // Register writeback and flag update both happen at the end of the first WB cycle.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    wb_first_d  = 1'b0;
    flags_d     = wb_first_q ? res_flags_q : flags_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_EXEC;
          alu_a_d  = rdata_a;
          alu_b_d  = rdata_b;
          alu_op_d = bus.in_op;
          rd_d     = bus.in_rd;
        end
      end
      S_EXEC: begin
        res_data_d  = alu_out;
        res_flags_d = {alu_flags[FLAG_S], alu_flags[FLAG_Z], alu_flags[FLAG_C]};
        wb_first_d  = 1'b1;
        state_d     = S_WB;
      end
      S_WB: begin
        if (res_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 3'b000;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      wb_first_q  <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      wb_first_q  <= wb_first_d;
      flags_q     <= flags_d;
    end
  end

`ifdef ALU_EXEC_PERF_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;

  assign retired_cnt   = retired_cnt_q;
  assign retired_cnt_d = res_fire ? retired_cnt_q + 32'd1 : retired_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_cnt_q <= '0;
    else        retired_cnt_q <= retired_cnt_d;
  end
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: table-driven vectors plus hand sequences,
// with a result scoreboard and a behavioural stand-in for the external ALU.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expData;
    logic [2:0]  expFlags;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic [2:0]  flags;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        host_we;
  logic [2:0]  host_waddr;
  logic [15:0] host_wdata;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op, alu_flags, flags_q;
`ifdef ALU_EXEC_PERF_EN
  logic [31:0] retired_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  sb_t         sb[$];
  vec_t        vecs[10];
  logic [15:0] expRegs[8];
  bit          flagPend = 0;
  logic [2:0]  flagExp;

  alu_exec_ctrl_if #(.NREGS(8), .DW(16)) bus();

  alu_exec_ctrl #(.NREGS(8), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .flags_q    (flags_q)
`ifdef ALU_EXEC_PERF_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {Sign, Zero, Carry}; SUB/CMP carry is borrow, CMP outputs zero.
  function automatic logic [18:0] aluModel(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    w = '0;
    c = 1'b0;
    case (op)
      3'b000: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
      3'b001: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16]; end
      3'b010: begin r = 16'h0000; c = (a < b); end
      3'b011: begin w = {1'b0, a} + 17'd1; r = w[15:0]; c = w[16]; end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = ~a;
      default: r = ~b;
    endcase
    return {r[15], (r == 16'h0000), c, r};
  endfunction

  always_comb {alu_flags, alu_out} = aluModel(alu_a, alu_b, alu_op);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s_reg%0d", tag, i), {16'h0, dut.u_rf.regs_q[i]}, {16'h0, expRegs[i]});
  endtask

  // Result monitor: samples shortly after the falling edge, after bench drives settle.
  always @(negedge clk) begin
    #2;
    if (flagPend) begin
      checkOutput("flags_q", {29'h0, flags_q}, {29'h0, flagExp});
      flagPend = 0;
    end
    if (rst_n && bus.res_valid && bus.res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got result 0x%0h with nothing expected", bus.res_data);
      end else begin
        sb_t e;
        e = sb.pop_front();
        checkOutput("res_data", {16'h0, bus.res_data}, {16'h0, e.data});
        checkOutput("res_rd", {29'h0, bus.res_rd}, {29'h0, e.rd});
        flagExp  = e.flags;
        flagPend = 1;
      end
    end
  end

  task automatic hostWrite(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    host_we    = 1'b1;
    host_waddr = addr;
    host_wdata = data;
    @(negedge clk);
    host_we    = 1'b0;
    expRegs[addr] = data;
  endtask

  // Drives one instruction, checks EXEC operands and N+2 latency; returns in the first WB cycle.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] expData, input logic [2:0] expFlags);
    int waitCnt;
    sb_t e;
    waitCnt = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    while (!bus.in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("accept_in_ready", {31'h0, bus.in_ready}, 32'h1);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    e.data  = expData;
    e.rd    = rd;
    e.flags = expFlags;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("exec_res_valid", {31'h0, bus.res_valid}, 32'h0);
    checkOutput("exec_alu_a", {16'h0, alu_a}, {16'h0, a});
    checkOutput("exec_alu_b", {16'h0, alu_b}, {16'h0, b});
    checkOutput("exec_alu_op", {29'h0, alu_op}, {29'h0, op});
    @(negedge clk);
    checkOutput("wb_res_valid", {31'h0, bus.res_valid}, 32'h1);
  endtask

  task automatic applyStimulus(input vec_t v);
    hostWrite(v.rs1, v.a);
    hostWrite(v.rs2, v.b);
    issue(v.op, v.rd, v.rs1, v.rs2, v.a, v.b, v.expData, v.expFlags);
    @(negedge clk);
    if (v.op != OP_CMP) expRegs[v.rd] = v.expData;
    checkRegs("vec");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{OP_ADD,  3'd3, 3'd1, 3'd2, 16'hFFFF, 16'h0001, 16'h0000, 3'b011};
    vecs[1] = '{OP_CMP,  3'd4, 3'd1, 3'd2, 16'h0005, 16'h0007, 16'h0000, 3'b011};
    vecs[2] = '{OP_SUB,  3'd6, 3'd1, 3'd2, 16'h0003, 16'h0005, 16'hFFFE, 3'b101};
    vecs[3] = '{OP_AND,  3'd7, 3'd1, 3'd2, 16'h0F0F, 16'h00FF, 16'h000F, 3'b000};
    vecs[4] = '{OP_OR,   3'd0, 3'd1, 3'd2, 16'hF000, 16'h000F, 16'hF00F, 3'b100};
    vecs[5] = '{OP_NOTA, 3'd5, 3'd1, 3'd2, 16'h00FF, 16'h1111, 16'hFF00, 3'b100};
    vecs[6] = '{OP_NOTB, 3'd2, 3'd1, 3'd2, 16'h5555, 16'h0000, 16'hFFFF, 3'b100};
    vecs[7] = '{OP_ADD,  3'd1, 3'd1, 3'd2, 16'h1234, 16'h1111, 16'h2345, 3'b000};
    vecs[8] = '{OP_INC,  3'd3, 3'd6, 3'd7, 16'hFFFF, 16'h0000, 16'h0000, 3'b011};
    vecs[9] = '{OP_SUB,  3'd2, 3'd1, 3'd2, 16'h0007, 16'h0007, 16'h0000, 3'b010};

    for (int i = 0; i < 8; i++) expRegs[i] = 16'h0000;
    rst_n         = 1'b0;
    host_we       = 1'b0;
    host_waddr    = '0;
    host_wdata    = '0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.res_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    checkOutput("rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
    checkOutput("rst_flags", {29'h0, flags_q}, 32'h0);
    checkOutput("rst_alu_op", {29'h0, alu_op}, 32'h0);
    checkRegs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] downstream stall");
    hostWrite(3'd1, 16'h0010);
    hostWrite(3'd2, 16'h0020);
    bus.res_ready = 1'b0;
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0010, 16'h0020, 16'h0030, 3'b000);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_SUB;
    bus.in_rd    = 3'd6;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_res_valid", {31'h0, bus.res_valid}, 32'h1);
      checkOutput("hold_res_data", {16'h0, bus.res_data}, 32'h0030);
      checkOutput("hold_res_rd", {29'h0, bus.res_rd}, 32'h3);
      checkOutput("hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    expRegs[3] = 16'h0030;
    checkRegs("stall");

    $display("[TB] host write collisions in WB");
    hostWrite(3'd1, 16'h0001);
    hostWrite(3'd2, 16'h0002);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0001, 16'h0002, 16'h0003, 3'b000);
    host_we = 1'b1; host_waddr = 3'd3; host_wdata = 16'h1234;
    @(negedge clk);
    host_we = 1'b0;
    expRegs[3] = 16'h0003;
    checkRegs("same_rd");
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0001, 16'h0002, 16'h0003, 3'b000);
    host_we = 1'b1; host_waddr = 3'd5; host_wdata = 16'hBEEF;
    @(negedge clk);
    host_we = 1'b0;
    expRegs[5] = 16'hBEEF;
    checkRegs("other_rd");

    $display("[TB] reset during EXEC");
    hostWrite(3'd1, 16'h0005);
    hostWrite(3'd2, 16'h0006);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_rd    = 3'd4;
    bus.in_rs1   = 3'd1;
    bus.in_rs2   = 3'd2;
    checkOutput("mid_accept_ready", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("mid_exec_alu_a", {16'h0, alu_a}, 32'h0005);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) expRegs[i] = 16'h0000;
    checkOutput("mid_rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
    checkOutput("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    checkOutput("mid_rst_alu_a", {16'h0, alu_a}, 32'h0);
    checkOutput("mid_rst_alu_b", {16'h0, alu_b}, 32'h0);
    checkOutput("mid_rst_res_data", {16'h0, bus.res_data}, 32'h0);
    checkOutput("mid_rst_flags", {29'h0, flags_q}, 32'h0);
    checkRegs("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
    checkRegs("post_rst");

    $display("[TB] back-to-back INC after reset");
    hostWrite(3'd1, 16'h7FFF);
    issue(OP_INC, 3'd1, 3'd1, 3'd0, 16'h7FFF, 16'h0000, 16'h8000, 3'b100);
    expRegs[1] = 16'h8000;
    issue(OP_INC, 3'd1, 3'd1, 3'd0, 16'h8000, 16'h0000, 16'h8001, 3'b100);
    @(negedge clk);
    expRegs[1] = 16'h8001;
    checkRegs("inc");
`ifdef ALU_EXEC_PERF_EN
    checkOutput("retired_cnt", retired_cnt, 32'd2);
`endif

    repeat (3) @(negedge clk);
    #3;
    checkOutput("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
